// File: rtl/boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// boot_loader_pkg
// Shared definitions for the instruction-memory boot loader, the pipelined
// core top and the benches.
//   state_e          : loader sequencer states
//   BL_ADDR_W        : default instruction-memory byte-address width
//   BL_DATA_W        : default instruction word width
//   BL_MAX_WORDS     : default instruction-memory capacity in words
//   BL_SETTLE_CYC    : default cycles between last write and core release
// ---------------------------------------------------------------------------
package boot_loader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SETTLE = 2'd2,
      RUN    = 2'd3
   } state_e;

   localparam int BL_ADDR_W     = 9;
   localparam int BL_DATA_W     = 32;
   localparam int BL_MAX_WORDS  = 128;
   localparam int BL_SETTLE_CYC = 2;

endpackage

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Loads a program into the core's instruction memory from a valid/ready word
// stream, then releases the core's PC from reset.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   one-cycle pulse, begins a load of word_count words
//   word_count in   words to load (sampled on start)
//   s_valid    in   source word valid
//   s_data     in   source instruction word
//   s_ready    out  loader accepts a word this cycle
//   we0        out  instruction memory write enable
//   wr_addr0   out  word-aligned byte address
//   wr_din0    out  write data
//   resetpc    out  0 = core PC held, 1 = core runs
//   busy       out  load or settle in progress
//   done       out  one-cycle pulse on core release
//   err        out  one-cycle pulse on a rejected start
// MAX_WORDS*4 must not exceed 2**ADDR_W for the addresses to fit.
// ---------------------------------------------------------------------------
module imem_boot_loader
   import boot_loader_pkg::*;
#(
   parameter int ADDR_W     = BL_ADDR_W,
   parameter int DATA_W     = BL_DATA_W,
   parameter int MAX_WORDS  = BL_MAX_WORDS,
   parameter int SETTLE_CYC = BL_SETTLE_CYC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        word_count,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              we0,
   output logic [ADDR_W-1:0] wr_addr0,
   output logic [DATA_W-1:0] wr_din0,
   output logic              resetpc,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_e            state_q, state_d;
   logic [7:0]        idx_q, idx_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [7:0]        settle_q, settle_d;
   logic              we0_q, we0_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              startOk;

   // A start is legal only for a non-empty program that fits in memory.
   assign startOk = (word_count != 8'd0) && ({24'd0, word_count} <= MAX_WORDS);

   // Handshake and core control decode straight from the state register, so
   // s_ready drops on the same edge that takes the final accept into SETTLE
   // and busy falls on the edge that raises resetpc.
   assign s_ready  = (state_q == LOAD);
   assign busy     = (state_q == LOAD) || (state_q == SETTLE);
   assign resetpc  = (state_q == RUN);
   assign we0      = we0_q;
   assign wr_addr0 = addr_q;
   assign wr_din0  = din_q;
   assign done     = done_q;
   assign err      = err_q;

   // State and registered write-port outputs; reset returns everything to
   // idle values but memory contents written so far are left alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         idx_q    <= 8'd0;
         cnt_q    <= 8'd0;
         settle_q <= 8'd0;
         we0_q    <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         we0_q    <= we0_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Next-state logic. SETTLE's first cycle is the final write cycle, so the
   // settle counter runs 0..SETTLE_CYC to give 1+SETTLE_CYC cycles from the
   // last accept to release.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      settle_d = settle_q;
      we0_d    = 1'b0;
      addr_d   = addr_q;
      din_d    = din_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         IDLE, RUN: begin
            if (start) begin
               if (startOk) begin
                  state_d = LOAD;
                  cnt_d   = word_count;
                  idx_d   = 8'd0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (s_valid) begin
               we0_d  = 1'b1;
               addr_d = ADDR_W'({idx_q, 2'b00});
               din_d  = s_data;
               idx_d  = idx_q + 8'd1;
               if (idx_q == cnt_q - 8'd1) begin
                  state_d  = SETTLE;
                  settle_d = 8'd0;
               end
            end
         end
         SETTLE: begin
            if (settle_q == 8'(SETTLE_CYC)) begin
               state_d = RUN;
               done_d  = 1'b1;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
